// File: rtl/sudoku_entry_ctrl_if.sv
// Signal bundle between the Sudoku game-flow controller, its two cell-write
// requesters and the solver write/load port.
interface sudoku_entry_ctrl_if #(
  parameter int unsigned MOVE_W = 10,
  parameter int unsigned TIME_W = 12
);
  logic              new_game;
  logic              hw_req;
  logic [3:0]        hw_row;
  logic [3:0]        hw_col;
  logic [3:0]        hw_data;
  logic              hw_ack;
  logic              key_req;
  logic [3:0]        key_row;
  logic [3:0]        key_col;
  logic [3:0]        key_data;
  logic              key_ack;
  logic              req_err;
  logic [80:0]       board_blank;
  logic              sol_valid;
  logic              sol_start;
  logic              sol_read;
  logic [3:0]        sol_row;
  logic [3:0]        sol_col;
  logic [3:0]        sol_data;
  logic              solved;
  logic [MOVE_W-1:0] move_cnt;
  logic [TIME_W-1:0] elapsed_sec;

  modport slave (
    input  new_game,
    input  hw_req, hw_row, hw_col, hw_data,
    output hw_ack,
    input  key_req, key_row, key_col, key_data,
    output key_ack,
    output req_err,
    input  board_blank,
    input  sol_valid,
    output sol_start, sol_read, sol_row, sol_col, sol_data,
    output solved, move_cnt, elapsed_sec
  );

  modport master (
    output new_game,
    output hw_req, hw_row, hw_col, hw_data,
    input  hw_ack,
    output key_req, key_row, key_col, key_data,
    input  key_ack,
    input  req_err,
    output board_blank,
    output sol_valid,
    input  sol_start, sol_read, sol_row, sol_col, sol_data,
    input  solved, move_cnt, elapsed_sec
  );
endinterface

// File: rtl/sudoku_entry_ctrl.sv
// Sudoku game-flow controller: starts games, arbitrates hw/keypad cell writes
// into the solver, detects completion and tracks moves and elapsed seconds.
module sudoku_entry_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MOVE_W   = 10,
  parameter int unsigned TIME_W   = 12
) (
  input logic                clk,
  input logic                reset_n,
  sudoku_entry_ctrl_if.slave bus
);
  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_EDIT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              rr_last;      // 1 = keypad was granted last
  logic              last_acc;
  logic              hw_ack_q, key_ack_q, req_err_q;
  logic              sol_start_q, sol_read_q, solved_q;
  logic [3:0]        sol_row_q, sol_col_q, sol_data_q;
  logic [MOVE_W-1:0] move_q;
  logic [TIME_W-1:0] elap_q;
  logic [PW-1:0]     presc_q;

  logic       any_req, pick_key, cell_ok, ack_busy, grant, accept, timed;
  logic [3:0] sel_row, sel_col, sel_data;
  logic [6:0] idx;

  // Arbitration and legality of the request that would be granted this cycle
  always_comb begin
    any_req  = bus.hw_req | bus.key_req;
    pick_key = bus.key_req & (~bus.hw_req | ~rr_last);
    sel_row  = pick_key ? bus.key_row  : bus.hw_row;
    sel_col  = pick_key ? bus.key_col  : bus.hw_col;
    sel_data = pick_key ? bus.key_data : bus.hw_data;
    idx      = 7'(sel_row) * 7'd9 + 7'(sel_col);
    cell_ok  = 1'b0;
    if (sel_row <= 4'd8 && sel_col <= 4'd8 && sel_data <= 4'd9)
      cell_ok = bus.board_blank[idx];
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    // In IDLE/DONE a reject completes in one cycle, so a req still high
    // during its own ack cycle must not be granted a second time.
    ack_busy = hw_ack_q | key_ack_q;
    unique case (state)
      S_IDLE:  grant = any_req & ~ack_busy;
      S_START: state_nx = S_EDIT;
      S_EDIT: begin
        if (any_req) begin
          grant    = 1'b1;
          state_nx = S_WRITE;
        end
      end
      S_WRITE: state_nx = S_CHECK;
      S_CHECK: state_nx = (bus.sol_valid && last_acc) ? S_DONE : S_EDIT;
      S_DONE:  grant = any_req & ~ack_busy;
      default: state_nx = S_IDLE;
    endcase
    if (bus.new_game) begin
      state_nx = S_START;
      grant    = 1'b0;
    end
    accept = grant && (state == S_EDIT) && cell_ok;
    timed  = (state == S_EDIT) || (state == S_WRITE) || (state == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rr_last     <= 1'b1;
      last_acc    <= 1'b0;
      hw_ack_q    <= 1'b0;
      key_ack_q   <= 1'b0;
      req_err_q   <= 1'b0;
      sol_start_q <= 1'b0;
      sol_read_q  <= 1'b0;
      sol_row_q   <= '0;
      sol_col_q   <= '0;
      sol_data_q  <= '0;
      solved_q    <= 1'b0;
      move_q      <= '0;
      elap_q      <= '0;
      presc_q     <= '0;
    end else begin
      state       <= state_nx;
      hw_ack_q    <= grant & ~pick_key;
      key_ack_q   <= grant & pick_key;
      req_err_q   <= grant & ~accept;
      sol_read_q  <= accept;
      sol_start_q <= (state_nx == S_START);
      if (grant) begin
        rr_last  <= pick_key;
        last_acc <= accept;
      end
      if (accept) begin
        sol_row_q  <= sel_row;
        sol_col_q  <= sel_col;
        sol_data_q <= sel_data;
      end
      if (state_nx == S_START) begin
        solved_q <= 1'b0;
        move_q   <= '0;
        elap_q   <= '0;
        presc_q  <= '0;
      end else begin
        if (accept && move_q != '1)
          move_q <= move_q + 1'b1;
        if (timed) begin
          if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            if (elap_q != '1)
              elap_q <= elap_q + 1'b1;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        if (state == S_CHECK && state_nx == S_DONE)
          solved_q <= 1'b1;
      end
    end
  end

  assign bus.hw_ack      = hw_ack_q;
  assign bus.key_ack     = key_ack_q;
  assign bus.req_err     = req_err_q;
  assign bus.sol_start   = sol_start_q;
  assign bus.sol_read    = sol_read_q;
  assign bus.sol_row     = sol_row_q;
  assign bus.sol_col     = sol_col_q;
  assign bus.sol_data    = sol_data_q;
  assign bus.solved      = solved_q;
  assign bus.move_cnt    = move_q;
  assign bus.elapsed_sec = elap_q;
endmodule

// File: tb/tb_sudoku_entry_ctrl.sv
// Directed bench for sudoku_entry_ctrl: inputs driven and outputs checked on
// the falling edge, one step per clock.
module tb_sudoku_entry_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sudoku_entry_ctrl_if #(.MOVE_W(10), .TIME_W(12)) bus ();

  sudoku_entry_ctrl #(
    .TICK_DIV(4),
    .MOVE_W  (10),
    .TIME_W  (12)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hw(input logic r, input logic [3:0] row, input logic [3:0] col,
                        input logic [3:0] data);
    bus.hw_req  = r;
    bus.hw_row  = row;
    bus.hw_col  = col;
    bus.hw_data = data;
  endtask

  task automatic set_key(input logic r, input logic [3:0] row, input logic [3:0] col,
                         input logic [3:0] data);
    bus.key_req  = r;
    bus.key_row  = row;
    bus.key_col  = col;
    bus.key_data = data;
  endtask

  task automatic chk_write(input string tag, input logic hw, input logic key, input logic err,
                           input logic rd, input int mv);
    chk({tag, "_hw_ack"},   32'(bus.hw_ack),   32'(hw));
    chk({tag, "_key_ack"},  32'(bus.key_ack),  32'(key));
    chk({tag, "_req_err"},  32'(bus.req_err),  32'(err));
    chk({tag, "_sol_read"}, 32'(bus.sol_read), 32'(rd));
    chk({tag, "_move_cnt"}, 32'(bus.move_cnt), 32'(mv));
  endtask

  task automatic chk_cell(input string tag, input int r, input int c, input int d);
    chk({tag, "_row"},  32'(bus.sol_row),  32'(r));
    chk({tag, "_col"},  32'(bus.sol_col),  32'(c));
    chk({tag, "_data"}, 32'(bus.sol_data), 32'(d));
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.new_game    = 1'b0;
    bus.sol_valid   = 1'b0;
    bus.board_blank = '1;
    bus.board_blank[40] = 1'b0;
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);

    // Reset and the cycle after it
    tickn(2);
    chk_write("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rst_sol_start", 32'(bus.sol_start), 32'd0);
    chk("rst_solved",    32'(bus.solved),    32'd0);
    chk("rst_elapsed",   32'(bus.elapsed_sec), 32'd0);
    chk_cell("rst", 0, 0, 0);
    reset_n = 1'b1;
    tick();
    chk_write("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("post_rst_sol_start", 32'(bus.sol_start), 32'd0);

    // IDLE: keypad request rejected
    set_key(1'b1, 4'd0, 4'd0, 4'd1);
    tick();
    chk_write("idle_rej", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);
    bus.new_game = 1'b1;

    // New game
    tick();
    chk("start_pulse", 32'(bus.sol_start), 32'd1);
    chk_write("start", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("start_elapsed", 32'(bus.elapsed_sec), 32'd0);
    bus.new_game = 1'b0;
    set_hw(1'b1, 4'd0, 4'd0, 4'd1);
    set_key(1'b1, 4'd1, 4'd1, 4'd2);
    tick();
    chk("start_end", 32'(bus.sol_start), 32'd0);
    chk_write("start_edit", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Round robin: hw, key, hw, key with 3-cycle spacing
    tick();
    chk_write("rr1", 1'b1, 1'b0, 1'b0, 1'b1, 1);
    chk_cell("rr1", 0, 0, 1);
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    chk_write("rr1_end", 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk_cell("rr1_hold", 0, 0, 1);
    set_hw(1'b1, 4'd0, 4'd1, 4'd3);
    tickn(2);
    chk_write("rr2", 1'b0, 1'b1, 1'b0, 1'b1, 2);
    chk_cell("rr2", 1, 1, 2);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    set_key(1'b1, 4'd1, 4'd2, 4'd4);
    tickn(2);
    chk_write("rr3", 1'b1, 1'b0, 1'b0, 1'b1, 3);
    chk_cell("rr3", 0, 1, 3);
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);
    tickn(3);
    chk_write("rr4", 1'b0, 1'b1, 1'b0, 1'b1, 4);
    chk_cell("rr4", 1, 2, 4);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);

    // Single hw write, raised during CHECK
    tick();
    set_hw(1'b1, 4'd2, 4'd3, 4'd5);
    tickn(2);
    chk_write("hw_wr", 1'b1, 1'b0, 1'b0, 1'b1, 5);
    chk_cell("hw_wr", 2, 3, 5);
    chk("hw_wr_elapsed", 32'(bus.elapsed_sec), 32'd3);
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);

    // Rejects: fixed cell, row 9, digit 10
    tick();
    set_key(1'b1, 4'd4, 4'd4, 4'd7);
    tickn(2);
    chk_write("rej_fixed", 1'b0, 1'b1, 1'b1, 1'b0, 5);
    chk_cell("rej_fixed_hold", 2, 3, 5);
    chk("rej_fixed_elapsed", 32'(bus.elapsed_sec), 32'd4);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    set_key(1'b1, 4'd9, 4'd0, 4'd1);
    tickn(2);
    chk_write("rej_row9", 1'b0, 1'b1, 1'b1, 1'b0, 5);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    set_hw(1'b1, 4'd0, 4'd2, 4'd10);
    tickn(2);
    chk_write("rej_data10", 1'b1, 1'b0, 1'b1, 1'b0, 5);
    chk_cell("rej_data10_hold", 2, 3, 5);
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);
    bus.sol_valid = 1'b1;

    // Valid board after a rejected write is not a solve
    tickn(2);
    chk("rej_valid_not_solved", 32'(bus.solved), 32'd0);
    bus.sol_valid = 1'b0;
    set_hw(1'b1, 4'd8, 4'd8, 4'd9);

    // Final write at the last cell completes the board
    tick();
    chk_write("final_wr", 1'b1, 1'b0, 1'b0, 1'b1, 6);
    chk_cell("final_wr", 8, 8, 9);
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    chk("final_write_state", 32'(bus.solved), 32'd0);
    bus.sol_valid = 1'b1;
    tick();
    chk("solved", 32'(bus.solved), 32'd1);
    chk("solved_elapsed", 32'(bus.elapsed_sec), 32'd6);
    set_key(1'b1, 4'd5, 4'd5, 4'd1);
    tick();
    chk_write("done_rej", 1'b0, 1'b1, 1'b1, 1'b0, 6);
    set_key(1'b0, 4'd0, 4'd0, 4'd0);
    tickn(6);
    chk("done_elapsed_frozen", 32'(bus.elapsed_sec), 32'd6);
    chk("done_solved_held", 32'(bus.solved), 32'd1);

    // Restart from DONE
    bus.new_game  = 1'b1;
    bus.sol_valid = 1'b0;
    tick();
    chk("restart_pulse",   32'(bus.sol_start),   32'd1);
    chk("restart_solved",  32'(bus.solved),      32'd0);
    chk("restart_elapsed", 32'(bus.elapsed_sec), 32'd0);
    chk("restart_moves",   32'(bus.move_cnt),    32'd0);
    bus.new_game = 1'b0;

    // new_game beats a pending grant and a coincident prescaler wrap
    tickn(16);
    chk("pre_clash_elapsed", 32'(bus.elapsed_sec), 32'd3);
    bus.new_game = 1'b1;
    set_hw(1'b1, 4'd3, 4'd3, 4'd3);
    tick();
    chk_write("clash", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("clash_pulse",   32'(bus.sol_start),   32'd1);
    chk("clash_elapsed", 32'(bus.elapsed_sec), 32'd0);
    chk("clash_solved",  32'(bus.solved),      32'd0);
    bus.new_game = 1'b0;
    set_hw(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    chk("clash_start_end", 32'(bus.sol_start), 32'd0);
    tickn(3);
    chk("regain_elapsed0", 32'(bus.elapsed_sec), 32'd0);
    tick();
    chk("regain_elapsed1", 32'(bus.elapsed_sec), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
